pipe_fifo: RTL and testbench
============================

// Module: pipe_fifo
// PURPOSE
//   Elastic buffer placed directly downstream of a pipe_stage: accepts its o_data/o_vld,
//   drives its i_rdy, and re-presents words in order on an identical valid/ready port.
//   Absorbs DEPTH words of back-pressure so upstream stages keep streaming while the
//   consumer stalls. No combinational path crosses it (ready and valid both registered-derived).
// PARAMETERS
//   WIDTH  8  data word width in bits
//   DEPTH  4  storage entries; power of two, >= 2; AW = $clog2(DEPTH)
// PORTS
//   i_clk      in   1        clock, all state on rising edge
//   i_reset    in   1        asynchronous, active-high reset
//   i_data     in   WIDTH    upstream data
//   i_vld      in   1        upstream valid
//   o_rdy      out  1        ready to upstream
//   o_data     out  WIDTH    downstream data (head of queue)
//   o_vld      out  1        downstream valid
//   i_rdy      in   1        downstream ready
//   o_count    out  AW+1     current occupancy, 0..DEPTH
// BEHAVIOUR
//   - push = i_vld & o_rdy; pop = o_vld & i_rdy; each is one transfer per cycle.
//   - State: mem[DEPTH] (not reset), wr_ptr/rd_ptr (AW bits), count (AW+1 bits).
//   - o_rdy = ~i_reset & (count != DEPTH); o_vld = (count != 0); o_data = mem[rd_ptr].
//     All three depend only on registered state (o_rdy also on i_reset), never on
//     i_vld or i_rdy.
//   - Reset (async assert, sync release by design): count=0, wr_ptr=0, rd_ptr=0,
//     o_vld=0, o_count=0, o_rdy=0 while i_reset high, 1 first cycle after release.
//     o_data is don't-care while o_vld=0.
//   - Push: mem[wr_ptr]<=i_data, wr_ptr<=wr_ptr+1 (wraps mod DEPTH).
//     Pop: rd_ptr<=rd_ptr+1 (wraps mod DEPTH).
//   - count: push&~pop -> +1; pop&~push -> -1; both or neither -> unchanged.
//   - Latency: word pushed at edge N is on o_data with o_vld=1 after edge N
//     (first-word-fall-through, 1 cycle in->out when empty).
//   - Full (count==DEPTH): o_rdy=0, i_vld ignored; a pop that cycle frees one slot,
//     o_rdy=1 next cycle (one-cycle bubble by design; full throughput needs DEPTH>=2).
//   - Empty: o_vld=0, i_rdy ignored; simultaneous push lands, no pop.
//   - Simultaneous push+pop at 0<count<DEPTH: both occur, order preserved, count held.
//   - Reset mid-operation: all queued words discarded, no partial word emitted.
//   - Downstream may drop i_rdy at any time; o_data/o_vld hold stable until popped.
// CONFIGURATION
//   PIPE_FIFO_PEAK_EN defined: adds output o_peak [AW:0], the high-water mark of count.
//     o_peak resets to 0; each cycle o_peak <= max(o_peak, next count). It holds,
//     never decreases, and is cleared only by i_reset.
//   Not defined: port o_peak and its register are absent; all other behaviour identical.
// TESTING
//   1 Reset: assert i_reset mid-stream -> o_vld=0, o_count=0, o_rdy=0;
//     release -> o_rdy=1 next cycle.
//   2 Stream: i_rdy=1, push 0x01..0x10 back-to-back -> same 16 words out in order,
//     o_count<=1, one word per cycle after 1-cycle latency.
//   3 Fill: i_rdy=0, push 0xA0..0xA3 (DEPTH=4) -> o_count=4, o_rdy=0, 5th word
//     0xA4 held upstream; i_rdy=1 -> A0,A1,A2,A3,A4 out.
//   4 Wrap: alternate bursts of 3 pushes and 2 pops for 20 cycles with random i_rdy
//     -> scoreboard matches, pointers wrap cleanly, o_count tracks reference model.
//   5 Simultaneous: count=2, push 0x55 and pop same cycle -> count stays 2,
//     0x55 emerges after the 2 older words.
//   6 PIPE_FIFO_PEAK_EN: fill to 3 then drain to 0 -> o_peak=3 held;
//     i_reset -> o_peak=0.

Source files
------------

// File: rtl/pipe_fifo.sv
// First-word-fall-through elastic buffer with registered-only valid/ready/data outputs.
// Optional high-water-mark output o_peak when PIPE_FIFO_PEAK_EN is defined.
module pipe_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_vld,
    output logic             o_rdy,
    output logic [WIDTH-1:0] o_data,
    output logic             o_vld,
    input  logic             i_rdy,
`ifdef PIPE_FIFO_PEAK_EN
    output logic [AW:0]      o_peak,
`endif
    output logic [AW:0]      o_count
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_nxt;
    logic             w_push;
    logic             w_pop;

    // Handshake outputs come only from registered state so no comb path crosses the buffer.
    assign o_rdy   = ~i_reset & (r_count != CNT_FULL);
    assign o_vld   = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    assign w_push = i_vld & o_rdy;
    assign w_pop  = o_vld & i_rdy;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage is data only and is left unreset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
        end
    end

`ifdef PIPE_FIFO_PEAK_EN
    logic [AW:0] r_peak;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_peak <= '0;
        end else if (w_count_nxt > r_peak) begin
            r_peak <= w_count_nxt;
        end
    end

    assign o_peak = r_peak;
`endif

endmodule

// File: tb/tb_pipe_fifo.sv
// Randomized scoreboard bench for pipe_fifo: a queue-based reference model tracks
// contents and occupancy; a negedge monitor compares every handshake and status output.
module tb_pipe_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_vld = 1'b0;
    logic             out_rdy_dn = 1'b0;
    logic             fifo_rdy;
    logic [WIDTH-1:0] out_data;
    logic             out_vld;
    logic [AW:0]      count;
`ifdef PIPE_FIFO_PEAK_EN
    logic [AW:0]      peak;
`endif

    pipe_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_data  (in_data),
        .i_vld   (in_vld),
        .o_rdy   (fifo_rdy),
        .o_data  (out_data),
        .o_vld   (out_vld),
        .i_rdy   (out_rdy_dn),
`ifdef PIPE_FIFO_PEAK_EN
        .o_peak  (peak),
`endif
        .o_count (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] model_q [$];
    int               model_peak = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: state seen at negedge is the state after the last rising edge; the
    // inputs seen here are the ones the next rising edge will act on.
    always @(negedge clk) begin
        int  sz;
        bit  m_pop;
        bit  m_push;
        if (rst) begin
            chk("rst_vld", 32'(out_vld), 32'd0);
            chk("rst_cnt", 32'(count), 32'd0);
            chk("rst_rdy", 32'(fifo_rdy), 32'd0);
            model_q.delete();
            model_peak = 0;
`ifdef PIPE_FIFO_PEAK_EN
            chk("rst_peak", 32'(peak), 32'd0);
`endif
        end else begin
            sz = model_q.size();
            chk("count", 32'(count), 32'(sz));
            chk("vld", 32'(out_vld), 32'(sz != 0));
            chk("rdy", 32'(fifo_rdy), 32'(sz != DEPTH));
`ifdef PIPE_FIFO_PEAK_EN
            chk("peak", 32'(peak), 32'(model_peak));
`endif
            m_pop  = (sz != 0) && out_rdy_dn;
            m_push = in_vld && (sz != DEPTH);
            if (m_pop) begin
                chk("data", 32'(out_data), 32'(model_q[0]));
                void'(model_q.pop_front());
            end
            if (m_push) model_q.push_back(in_data);
            if (model_q.size() > model_peak) model_peak = model_q.size();
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a word and hold it until the buffer accepts it.
    task automatic push_word(input logic [WIDTH-1:0] d);
        bit acc;
        int n;
        in_data = d;
        in_vld  = 1'b1;
        n = 0;
        forever begin
            acc = fifo_rdy;
            step();
            if (acc) break;
            n++;
            if (n > 200) begin
                $display("FAIL push_timeout actual=stalled expected=accept word 0x%0h", d);
                errors++;
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "push timeout");
            end
        end
        in_vld = 1'b0;
    endtask

    task automatic drain();
        in_vld     = 1'b0;
        out_rdy_dn = 1'b1;
        step(DEPTH + 3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step();
    endtask

    initial begin
        // 1: reset, then reset in the middle of a partially filled stream
        step(3);
        rst = 1'b0;
        step();
        out_rdy_dn = 1'b0;
        push_word(8'h31);
        push_word(8'h32);
        push_word(8'h33);
        in_data = 8'h34;
        in_vld  = 1'b1;
        do_reset();
        in_vld = 1'b0;
        step(2);

        // 2: back-to-back stream with consumer always ready
        out_rdy_dn = 1'b1;
        for (int i = 1; i <= 16; i++) push_word(8'(i));
        drain();

        // 3: fill while stalled, fifth word waits upstream
        out_rdy_dn = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'hA0 + 8'(i));
        in_data = 8'hA4;
        in_vld  = 1'b1;
        step(3);
        out_rdy_dn = 1'b1;
        push_word(8'hA4);
        drain();

        // 4: bursts of 3 push cycles and 2 pop cycles, random ready, then free random traffic
        for (int c = 0; c < 20; c++) begin
            if ((c % 5) < 3) begin
                in_vld     = 1'b1;
                in_data    = 8'($urandom);
                out_rdy_dn = 1'($urandom_range(0, 1));
            end else begin
                in_vld     = 1'b0;
                out_rdy_dn = 1'b1;
            end
            step();
        end
        for (int c = 0; c < 300; c++) begin
            in_vld     = 1'($urandom_range(0, 3) != 0);
            in_data    = 8'($urandom);
            out_rdy_dn = 1'($urandom_range(0, 2) != 0);
            step();
        end
        drain();

        // 5: simultaneous push and pop at count 2
        out_rdy_dn = 1'b0;
        push_word(8'h11);
        push_word(8'h22);
        in_data    = 8'h55;
        in_vld     = 1'b1;
        out_rdy_dn = 1'b1;
        step();
        in_vld     = 1'b0;
        out_rdy_dn = 1'b0;
        step(2);
        drain();

`ifdef PIPE_FIFO_PEAK_EN
        // 6: high-water mark holds after drain, clears on reset
        do_reset();
        out_rdy_dn = 1'b0;
        for (int i = 0; i < 3; i++) push_word(8'hC0 + 8'(i));
        drain();
        step(3);
        chk("peak_hold", 32'(peak), 32'd3);
        do_reset();
        chk("peak_clear", 32'(peak), 32'd0);
`endif

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "global timeout");
    end

endmodule
